hdmi_cmd_scheduler: RTL

//  Buffered, parametrised command front-end for the HDMI command encoder. Accepts an AXI-Stream
//  of per-channel 10-bit command words plus a repeat count, queues them in a FIFO, and emits one

---
 rtl/hdmi_cmd_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hdmi_cmd_scheduler.sv
// rtl/hdmi_cmd_scheduler.sv - buffered command front-end feeding the HDMI serializers
//
// Queues per-channel 10-bit command words with a repeat count and emits one registered
// word set per pixel clock. Output starts only once PREFILL commands are queued; an
// empty queue while streaming inserts the idle word and drops back to filling.
//
// Ports:
//   clk_px          pixel clock, rising edge
//   reset           asynchronous active-high reset
//   cmd_tdata       {repeat, ch[CHANNELS-1] word, ..., ch[0] word}
//   cmd_tvalid      command valid
//   cmd_tready      command accepted when high together with cmd_tvalid
//   flush           discard the queue and return to filling
//   pulse_word      pulse-lane word (0 in reset, PULSE_WORD afterwards)
//   data_words      data-lane words, channel i at [10*i+9:10*i]
//   fill_level      commands currently queued
//   underflow_count saturating count of underflow events
//   streaming       high while the scheduler is emitting queued commands
module hdmi_cmd_scheduler #(
    parameter int         CHANNELS   = 3,
    parameter int         REP_W      = 8,
    parameter int         DEPTH      = 16,
    parameter int         PREFILL    = 4,
    parameter logic [9:0] IDLE_WORD  = 10'b1101010100,
    parameter logic [9:0] PULSE_WORD = 10'b1111100000
) (
    input  logic                          clk_px,
    input  logic                          reset,
    input  logic [10*CHANNELS+REP_W-1:0]  cmd_tdata,
    input  logic                          cmd_tvalid,
    output logic                          cmd_tready,
    input  logic                          flush,
    output logic [9:0]                    pulse_word,
    output logic [10*CHANNELS-1:0]        data_words,
    output logic [$clog2(DEPTH):0]        fill_level,
    output logic [15:0]                   underflow_count,
    output logic                          streaming
);

    localparam int CMD_W  = 10*CHANNELS + REP_W;
    localparam int DATA_W = 10*CHANNELS;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;

    typedef enum logic {ST_FILL, ST_RUN} state_t;

    state_t             state, state_nx;
    logic [CMD_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [REP_W-1:0]   rep_cnt;
    logic [15:0]        uf_cnt;
    logic [CMD_W-1:0]   head;
    logic               push, pop, underflow;

    assign head            = mem[rd_ptr];
    assign underflow_count = uf_cnt;
    assign streaming       = (state == ST_RUN);

    // Ready ignores a pop in the same cycle so a full queue never accepts.
    assign cmd_tready = !reset && (fill_level < LW'(DEPTH)) && !flush;
    assign push       = cmd_tvalid && cmd_tready;

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        underflow = 1'b0;
        case (state)
            ST_FILL: begin
                if (!flush && fill_level >= LW'(PREFILL))
                    state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (flush) begin
                    state_nx = ST_FILL;
                end else if (rep_cnt == '0) begin
                    // A push in this cycle is not yet visible, so it cannot avert underflow.
                    if (fill_level != '0) begin
                        pop = 1'b1;
                    end else begin
                        underflow = 1'b1;
                        state_nx  = ST_FILL;
                    end
                end
            end
            default: state_nx = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_px or posedge reset) begin
        if (reset) begin
            state      <= ST_FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            rep_cnt    <= '0;
            uf_cnt     <= '0;
            pulse_word <= '0;
            data_words <= {CHANNELS{IDLE_WORD}};
        end else begin
            state      <= state_nx;
            pulse_word <= PULSE_WORD;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_level <= '0;
                rep_cnt    <= '0;
                data_words <= {CHANNELS{IDLE_WORD}};
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   fill_level <= fill_level + LW'(1);
                    2'b01:   fill_level <= fill_level - LW'(1);
                    default: fill_level <= fill_level;
                endcase

                if (pop) begin
                    data_words <= head[DATA_W-1:0];
                    rep_cnt    <= head[CMD_W-1 -: REP_W];
                end else if (state == ST_RUN && rep_cnt != '0) begin
                    rep_cnt <= rep_cnt - REP_W'(1);
                end else if (state != ST_RUN || underflow) begin
                    data_words <= {CHANNELS{IDLE_WORD}};
                end

                if (underflow && uf_cnt != 16'hFFFF)
                    uf_cnt <= uf_cnt + 16'd1;
            end
        end
    end

    // Storage needs no reset; pointers and fill_level define which entries are live.
    always_ff @(posedge clk_px) begin
        if (push)
            mem[wr_ptr] <= cmd_tdata;
    end

endmodule
